// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - phase countdown timer for the light sequencer, 1 s timebase, finished pulse per phase
// Optional macro PHASE_TIMER_EXTEND_EN enables the once-per-phase extension request.
module phase_timer #(
  parameter int CLK_HZ  = 10000,
  parameter int TICK_HZ = 1,
  parameter int EXT_SEC = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] secondsToCount,
  input  logic        ext_req,
  output logic        finished,
  output logic [15:0] remaining,
  output logic        tick
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [15:0] EXT_W = 16'(EXT_SEC);

  typedef enum logic [1:0] {KICK, DONE, LOAD, COUNT} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          tick_q;
  logic          last;
  logic [15:0]   rem_dec;
  logic          ext_take;
  logic [15:0]   ext_val;

  assign last    = (prescaler == PS_LAST);
  assign rem_dec = (remaining != 16'd0) ? remaining - 16'd1 : 16'd0;

`ifdef PHASE_TIMER_EXTEND_EN
  logic        ext_used;
  logic [16:0] ext_sum;

  // A coincident final tick is folded in first, so the extension keeps the phase alive.
  assign ext_sum  = {1'b0, (last ? rem_dec : remaining)} + {1'b0, EXT_W};
  assign ext_val  = ext_sum[16] ? 16'hFFFF : ext_sum[15:0];
  assign ext_take = (state == COUNT) && ext_req && !ext_used && (remaining <= EXT_W);
`else
  assign ext_val  = remaining;
  assign ext_take = ext_req & 1'b0 & (EXT_W == 16'd0);
`endif

  // Outputs are gated by enable so a frozen DONE or tick is issued on the first enabled cycle.
  assign finished = (state == DONE) && enable;
  assign tick     = tick_q && enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= KICK;
      prescaler <= '0;
      remaining <= 16'd0;
      tick_q    <= 1'b0;
`ifdef PHASE_TIMER_EXTEND_EN
      ext_used  <= 1'b0;
`endif
    end else if (enable) begin
      case (state)
        KICK: begin
          tick_q <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          tick_q <= 1'b0;
          state  <= LOAD;
        end
        LOAD: begin
          tick_q    <= 1'b0;
          remaining <= (secondsToCount == 16'd0) ? 16'd1 : secondsToCount;
          prescaler <= '0;
`ifdef PHASE_TIMER_EXTEND_EN
          ext_used  <= 1'b0;
`endif
          state     <= COUNT;
        end
        COUNT: begin
          if (last) begin
            prescaler <= '0;
            tick_q    <= 1'b1;
          end else begin
            prescaler <= prescaler + 1'b1;
            tick_q    <= 1'b0;
          end
          if (ext_take) begin
            remaining <= ext_val;
`ifdef PHASE_TIMER_EXTEND_EN
            ext_used  <= 1'b1;
`endif
          end else if (last) begin
            remaining <= rem_dec;
            if (remaining <= 16'd1) state <= DONE;
          end
        end
        default: state <= KICK;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - directed self-checking bench for phase_timer at PRESCALE=10
module tb_phase_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] secondsToCount = 16'd0;
  logic        ext_req = 1'b0;
  logic        finished;
  logic [15:0] remaining;
  logic        tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  phase_timer #(.CLK_HZ(10), .TICK_HZ(1), .EXT_SEC(5)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .secondsToCount(secondsToCount),
    .ext_req(ext_req),
    .finished(finished),
    .remaining(remaining),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Steps until finished or the cycle budget runs out, then checks latency from LOAD.
  task automatic wait_fin(input string tag, input int exp);
    while (!finished && cyc < exp + 20) step();
    check(tag, cyc, exp);
  endtask

  // Call while in DONE: supplies the next duration and advances into LOAD.
  task automatic to_load(input logic [15:0] secs);
    secondsToCount = secs;
    step();
    cyc = 0;
    check("load_no_pulse", finished, 0);
  endtask

  initial begin
    repeat (3) step();
    check("rst_remaining", remaining, 0);
    check("rst_finished", finished, 0);
    check("rst_tick", tick, 0);

    reset = 1'b0;
    repeat (3) step();
    check("kick_waits", finished, 0);
    enable = 1'b1;
    step();
    check("kick_pulse", finished, 1);

    // 3 s phase: tick every 10 cycles, finished at 31
    to_load(16'd3);
    step();
    check("s3_rem_start", remaining, 3);
    while (cyc < 10) step();
    check("s3_rem_c10", remaining, 3);
    check("s3_tick_c10", tick, 0);
    step();
    check("s3_rem_c11", remaining, 2);
    check("s3_tick_c11", tick, 1);
    step();
    check("s3_tick_c12", tick, 0);
    while (cyc < 21) step();
    check("s3_rem_c21", remaining, 1);
    wait_fin("s3_latency", 31);
    check("s3_rem_end", remaining, 0);

    // zero is treated as one second
    to_load(16'd0);
    step();
    check("s0_rem", remaining, 1);
    wait_fin("s0_latency", 11);

    // 4 s phase frozen for 25 cycles starting at COUNT cycle 15
    to_load(16'd4);
    while (cyc < 15) step();
    enable = 1'b0;
    repeat (25) step();
    check("frz_rem", remaining, 3);
    check("frz_finished", finished, 0);
    check("frz_tick", tick, 0);
    enable = 1'b1;
    wait_fin("frz_latency", 66);
    step();
    check("frz_single_pulse", finished, 0);

    // reset mid-count
    cyc = 0;
    secondsToCount = 16'd2;
    step();
    cyc = 0;
    while (cyc < 5) step();
    check("mid_rem", remaining, 2);
    reset = 1'b1;
    step();
    check("mid_rst_rem", remaining, 0);
    check("mid_rst_fin", finished, 0);
    reset = 1'b0;
    step();
    check("mid_rst_kick", finished, 1);

    // extension request at remaining=2, second request ignored
    to_load(16'd2);
    while (cyc < 3) step();
    ext_req = 1'b1;
    step();
    ext_req = 1'b0;
`ifdef PHASE_TIMER_EXTEND_EN
    check("ext_rem", remaining, 7);
`else
    check("ext_rem", remaining, 2);
`endif
    step();
    step();
    ext_req = 1'b1;
    step();
    ext_req = 1'b0;
`ifdef PHASE_TIMER_EXTEND_EN
    check("ext_second_ignored", remaining, 7);
    wait_fin("ext_latency", 71);
`else
    check("ext_second_ignored", remaining, 2);
    wait_fin("ext_latency", 21);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
